// File: rtl/lcd_apb_regs.sv
// LCD controller APB3 register file.
// Holds timing/control state, shadowed frame bases and interrupt status.
module lcd_apb_regs #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] CTRL_MASK = 32'h0001_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [31:0]       timh,
  output logic [31:0]       timv,
  output logic [31:0]       pol,
  output logic [31:0]       le,
  output logic [31:0]       upbase_act,
  output logic [31:0]       lpbase_act,
  output logic [31:0]       ctrl,
  input  logic [31:0]       upcurr,
  input  logic [31:0]       lpcurr,
  input  logic              frame_start,
  input  logic              fuf_p,
  input  logic              vcomp_p,
  input  logic              ber_p,
  output logic              lcd_int
);

  localparam int IW = ADDR_W - 2;

  localparam logic [IW-1:0] A_TIMH   = IW'(0);
  localparam logic [IW-1:0] A_TIMV   = IW'(1);
  localparam logic [IW-1:0] A_POL    = IW'(2);
  localparam logic [IW-1:0] A_LE     = IW'(3);
  localparam logic [IW-1:0] A_UPBASE = IW'(4);
  localparam logic [IW-1:0] A_LPBASE = IW'(5);
  localparam logic [IW-1:0] A_CTRL   = IW'(6);
  localparam logic [IW-1:0] A_INTMSK = IW'(7);
  localparam logic [IW-1:0] A_INTRAW = IW'(8);
  localparam logic [IW-1:0] A_INTST  = IW'(9);
  localparam logic [IW-1:0] A_INTCLR = IW'(10);
  localparam logic [IW-1:0] A_UPCURR = IW'(11);
  localparam logic [IW-1:0] A_LPCURR = IW'(12);

  typedef enum logic [1:0] {
    IDLE,
    ACC_WR,
    RD_WAIT,
    RD_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0] idx;
  logic          addr_lsb_unused;
  logic [31:0]   upbase_pend;
  logic [31:0]   lpbase_pend;
  logic [4:1]    intmsk;
  logic [4:1]    intraw;
  logic [4:1]    int_set;
  logic [4:1]    int_clr;
  logic [31:0]   rd_mux;
  logic          hit_timh, hit_timv, hit_pol, hit_le;
  logic          hit_up, hit_lp, hit_ctrl, hit_msk;
  logic          hit_raw, hit_st, hit_clr, hit_ucur, hit_lcur;
  logic          mapped;
  logic          acc_err;
  logic          wr_en;
  logic          rd_cap;

  assign idx             = paddr[ADDR_W-1:2];
  assign addr_lsb_unused = ^paddr[1:0];

  assign hit_timh = idx == A_TIMH;
  assign hit_timv = idx == A_TIMV;
  assign hit_pol  = idx == A_POL;
  assign hit_le   = idx == A_LE;
  assign hit_up   = idx == A_UPBASE;
  assign hit_lp   = idx == A_LPBASE;
  assign hit_ctrl = idx == A_CTRL;
  assign hit_msk  = idx == A_INTMSK;
  assign hit_raw  = idx == A_INTRAW;
  assign hit_st   = idx == A_INTST;
  assign hit_clr  = idx == A_INTCLR;
  assign hit_ucur = idx == A_UPCURR;
  assign hit_lcur = idx == A_LPCURR;

  assign mapped  = idx <= A_LPCURR;
  assign acc_err = !mapped
                 | (pwrite & (hit_raw | hit_st | hit_ucur | hit_lcur))
                 | (!pwrite & hit_clr);

  // APB state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // APB next state, handshake and write/capture strobes
  always_comb begin
    state_nx = state;
    pready   = 1'b0;
    wr_en    = 1'b0;
    rd_cap   = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable)
          state_nx = pwrite ? ACC_WR : RD_WAIT;
      end
      ACC_WR: begin
        pready   = 1'b1;
        wr_en    = psel & penable & pwrite & ~acc_err;
        state_nx = IDLE;
      end
      RD_WAIT: begin
        if (psel) begin
          rd_cap   = 1'b1;
          state_nx = RD_DONE;
        end else begin
          state_nx = IDLE;
        end
      end
      RD_DONE: begin
        pready   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pslverr = pready & acc_err;

  // read source select
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_timh: rd_mux = timh;
      hit_timv: rd_mux = timv;
      hit_pol:  rd_mux = pol;
      hit_le:   rd_mux = le;
      hit_up:   rd_mux = upbase_pend;
      hit_lp:   rd_mux = lpbase_pend;
      hit_ctrl: rd_mux = ctrl;
      hit_msk:  rd_mux = {27'd0, intmsk, 1'b0};
      hit_raw:  rd_mux = {27'd0, intraw, 1'b0};
      hit_st:   rd_mux = {27'd0, intraw & intmsk, 1'b0};
      hit_ucur: rd_mux = upcurr;
      hit_lcur: rd_mux = lpcurr;
      default:  rd_mux = '0;
    endcase
  end

  // read data register, loaded during the wait state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         prdata <= '0;
    else if (rd_cap) prdata <= acc_err ? '0 : rd_mux;
  end

  // plain configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timh   <= '0;
      timv   <= '0;
      pol    <= '0;
      le     <= '0;
      ctrl   <= '0;
      intmsk <= '0;
    end else if (wr_en) begin
      unique case (1'b1)
        hit_timh: timh   <= pwdata;
        hit_timv: timv   <= pwdata;
        hit_pol:  pol    <= pwdata;
        hit_le:   le     <= pwdata;
        hit_ctrl: ctrl   <= pwdata & CTRL_MASK;
        hit_msk:  intmsk <= pwdata[4:1];
        default: ;
      endcase
    end
  end

  // frame bases: pending copy from the bus, active copy at frame edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upbase_pend <= '0;
      lpbase_pend <= '0;
      upbase_act  <= '0;
      lpbase_act  <= '0;
    end else begin
      if (wr_en && hit_up) upbase_pend <= {pwdata[31:3], 3'b000};
      if (wr_en && hit_lp) lpbase_pend <= {pwdata[31:3], 3'b000};
      if (!ctrl[0] || frame_start) begin
        upbase_act <= upbase_pend;
        lpbase_act <= lpbase_pend;
      end
    end
  end

  assign int_set = {ber_p, vcomp_p, frame_start & ctrl[0], fuf_p};
  assign int_clr = (wr_en && hit_clr) ? pwdata[4:1] : 4'd0;

  // raw interrupt status; a new event beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) intraw <= '0;
    else     intraw <= (intraw & ~int_clr) | int_set;
  end

  assign lcd_int = |(intraw & intmsk);

endmodule

// File: doc/lcd_apb_regs.md
Name: lcd_apb_regs

Overview:
APB3 slave that implements the LCD controller register file and drives the register values into the LCD datapath. It is the bus-side writer and reader for the timing, polarity, base-address, control and interrupt registers that the LCD core consumes. Base-address writes are shadowed and take effect at a frame boundary. Raw interrupt status is collected from core event pulses, masked, and combined into a single interrupt line.

Parameters:
ADDR_W, 12, width of the APB offset (paddr), byte address within the 4 KB LCD window
CTRL_MASK, 32'h0001_FFFF, writable bits of LCD_CTRL; all other bits read 0

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_W  byte offset; bits[1:0] ignored
pwdata  in  32  write data
prdata  out  32  read data, valid when pready=1 on a read
pready  out  1  transfer complete
pslverr  out  1  error, valid with pready
timh, timv, pol, le  out  32 each  timing, polarity and line-end registers
upbase_act, lpbase_act  out  32 each  active frame base addresses
ctrl  out  32  LCD_CTRL; bit0 LcdEn
upcurr, lpcurr  in  32 each  current DMA addresses from the core (read-only)
frame_start  in  1  one-cycle pulse at the start of each frame
fuf_p, vcomp_p, ber_p  in  1 each  one-cycle event pulses: FIFO underflow, vertical compare, bus error
lcd_int  out  1  |(intraw & intmsk)

Behaviour:
- Register map (offset, access):
  - 0x000 TIMH rw; 0x004 TIMV rw; 0x008 POL rw; 0x00C LE rw
  - 0x010 UPBASE rw; 0x014 LPBASE rw; 0x018 CTRL rw
  - 0x01C INTMSK rw, bits[4:1]
  - 0x020 INTRAW ro; 0x024 INTSTAT ro (= intraw & intmsk); 0x028 INTCLR wo
  - 0x02C UPCURR ro; 0x030 LPCURR ro
  - Any other offset is unmapped.
- Reset: all registers, prdata, pready and pslverr are 0.
- APB FSM states: IDLE, ACC_WR, RD_WAIT, RD_DONE.
  - IDLE -> ACC_WR on psel & ~penable & pwrite.
  - IDLE -> RD_WAIT on psel & ~penable & ~pwrite.
  - ACC_WR: pready=1; the register updates at this clock edge (zero wait states). Next state IDLE.
  - RD_WAIT: pready=0; prdata is registered from the selected source. Next state RD_DONE.
  - RD_DONE: pready=1 with the stable prdata. Next state IDLE.
  - Net latency: writes complete in the first access cycle; reads insert exactly one wait state.
  - If psel drops mid-transfer, the FSM returns to IDLE and no register update occurs.
- pslverr=1 with pready on:
  - an unmapped offset;
  - a write to INTRAW, INTSTAT, UPCURR or LPCURR;
  - a read of INTCLR.
  - An errored write changes no state. An errored read returns prdata=0.
- Width rules:
  - UPBASE and LPBASE bits[2:0] are forced to 0 (doubleword aligned).
  - CTRL is stored as pwdata & CTRL_MASK.
  - INTMSK, INTRAW and INTCLR use bits[4:1]: 1=FUF, 2=LNBU, 3=VCOMP, 4=BER. Other bits read 0.
- Base shadowing:
  - A write to UPBASE/LPBASE updates the pending register; reads return the pending value.
  - While ctrl[0]=0, upbase_act/lpbase_act follow pending on the cycle after the write.
  - While ctrl[0]=1, act is loaded from pending on frame_start, and intraw[2] (LNBU) is set on the same edge.
  - An UPBASE write coinciding with frame_start: the act register loads the old pending value; the new value waits for the next frame_start.
- Interrupts:
  - fuf_p, vcomp_p and ber_p set intraw bits 1, 3 and 4 on the next edge.
  - Writing 1 to an INTCLR bit clears that intraw bit.
  - A set pulse coinciding with a clear of the same bit: set wins and the bit stays 1.
  - lcd_int is combinational from the registered intraw and intmsk.
- Asynchronous reset mid-transfer forces IDLE, pready=0, and all registers to 0 immediately.

Test Plan:
1. Write TIMH=0x1234_5678, then read TIMH -> write pready=1 in its first access cycle, pslverr=0; read pready=0 for one cycle, then pready=1 with prdata=0x1234_5678.
2. ctrl[0]=1; write UPBASE=0xA000_0007 -> UPBASE reads 0xA000_0000; upbase_act is unchanged until frame_start, then equals 0xA000_0000; intraw=0x04, and lcd_int=1 only if intmsk=0x04.
3. Read offset 0x040 -> pslverr=1, prdata=0. Write INTRAW=0xFFFF_FFFF -> pslverr=1, intraw unchanged.
4. intmsk=0x1E; pulse ber_p -> intraw=0x10, lcd_int=1. Write INTCLR=0x10 in the same cycle as ber_p -> intraw stays 0x10; a later INTCLR=0x10 -> intraw=0, lcd_int=0.
5. Write CTRL=0xFFFF_FFFF -> ctrl=0x0001_FFFF. With ctrl[0]=0, an LPBASE write makes lpbase_act follow on the next cycle, with no LNBU set.
6. Assert rst during RD_WAIT -> pready=0 and all outputs 0 immediately. After release, a new read completes normally.
